// File: rtl/video_timing_decoder.sv
// Receiver for a pixel-rate hsync/vsync/de stream: recovers active-area
// coordinates, measures frame geometry and tracks lock / timing errors.
module video_timing_decoder #(
    parameter int CORDW       = 10,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT_W   = 12
) (
    input  logic             pix_clk,
    input  logic             rst_pix_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             out_de,
    output logic [CORDW-1:0] out_sx,
    output logic [CORDW-1:0] out_sy,
    output logic             frame_start,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] v_active,
    output logic             locked,
    output logic             timing_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [CORDW-1:0]     CMAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WMAX  = '1;
    localparam int                   MCW   = $clog2(LOCK_FRAMES + 1);
    localparam logic [MCW-1:0]       MLOCK = MCW'(LOCK_FRAMES);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // Input samples, normalised so 1 always means "sync active"
    logic hs_q, vs_q, de_q;
    logic hs_p_q, vs_p_q, de_p_q;
    logic hs_lead, vs_lead, de_fall;

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            de_p_q <= 1'b0;
        end else begin
            hs_q   <= (hsync == HS_POL);
            vs_q   <= (vsync == VS_POL);
            de_q   <= de;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            de_p_q <= de_q;
        end
    end

    assign hs_lead = hs_q & ~hs_p_q;
    assign vs_lead = vs_q & ~vs_p_q;
    assign de_fall = ~de_q & de_p_q;

    logic             out_de_q, out_de_d;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic             fs_q;
    logic [CORDW-1:0] line_cnt_q, line_cnt_d, act_cnt_q, act_cnt_d;
    logic [CORDW-1:0] vline_q, vline_d, vact_q, vact_d;
    logic [CORDW-1:0] last_htot_q, last_htot_d, last_hact_q, last_hact_d;
    logic [CORDW-1:0] htot_q, htot_d, hact_q, hact_d, vtot_q, vtot_d, vacto_q, vacto_d;
    logic [CORDW-1:0] vtot_now, vact_now;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic             line_has_de, line_bad, frame_bad, wd_fire;

    state_t           state_q, state_d;
    logic [MCW-1:0]   match_q, match_d, match_inc;
    logic             bad_q, bad_d, bad_now;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             store;

    // Line closes on the hsync leading edge: the lead cycle itself starts the
    // next line, so the counters reload rather than clear.
    always_comb begin
        out_de_d    = de_q;
        sx_d        = '0;
        if (de_q)
            sx_d = de_p_q ? sat_inc(sx_q) : '0;
        sy_d        = sy_q;
        if (vs_lead)
            sy_d = '0;
        else if (de_fall)
            sy_d = sat_inc(sy_q);

        line_has_de = (act_cnt_q != '0);
        line_cnt_d  = hs_lead ? CORDW'(1) : sat_inc(line_cnt_q);
        act_cnt_d   = act_cnt_q;
        if (hs_lead)
            act_cnt_d = CORDW'(de_q);
        else if (de_q)
            act_cnt_d = sat_inc(act_cnt_q);

        // A line ending together with vsync belongs to the frame that ends
        vtot_now    = hs_lead ? sat_inc(vline_q) : vline_q;
        vact_now    = (hs_lead && line_has_de) ? sat_inc(vact_q) : vact_q;
        vline_d     = vs_lead ? '0 : vtot_now;
        vact_d      = vs_lead ? '0 : vact_now;

        last_htot_d = hs_lead ? line_cnt_q : last_htot_q;
        last_hact_d = (hs_lead && line_has_de) ? act_cnt_q : last_hact_q;

        // Blanking lines carry no de, so only their total is compared
        line_bad    = hs_lead && ((line_cnt_q != htot_q) || (line_cnt_q == CMAX) ||
                      (line_has_de && ((act_cnt_q != hact_q) || (act_cnt_q == CMAX))));
        frame_bad   = (vtot_now != vtot_q) || (vact_now != vacto_q) ||
                      (vtot_now == CMAX) || (vact_now == CMAX);

        wd_d        = hs_lead ? '0 : ((wd_q == WMAX) ? wd_q : wd_q + 1'b1);
        wd_fire     = (state_q != SEARCH) && (wd_q == WMAX);
    end

    assign match_inc = match_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        store    = 1'b0;
        bad_now  = bad_q | line_bad;
        case (state_q)
            SEARCH: begin
                bad_d = 1'b0;
                if (vs_lead)
                    state_d = MEASURE;
            end
            MEASURE: begin
                if (vs_lead) begin
                    store   = 1'b1;
                    match_d = '0;
                    bad_d   = 1'b0;
                    state_d = VERIFY;
                end
            end
            VERIFY, LOCKED: begin
                // One error pulse per bad frame; the frame is then thrown away
                if (line_bad && !bad_q) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                end
                if (line_bad)
                    bad_d = 1'b1;
                if (vs_lead) begin
                    if (bad_now) begin
                        state_d  = MEASURE;
                        bad_d    = 1'b0;
                        locked_d = 1'b0;
                    end else if (frame_bad) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                        bad_d    = 1'b0;
                    end else if (state_q == VERIFY) begin
                        match_d = match_inc;
                        if (match_inc >= MLOCK) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        if (wd_fire) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            bad_d    = 1'b0;
            state_d  = SEARCH;
        end
    end

    always_comb begin
        err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
        htot_d    = store ? last_htot_d : htot_q;
        hact_d    = store ? last_hact_d : hact_q;
        vtot_d    = store ? vtot_now    : vtot_q;
        vacto_d   = store ? vact_now    : vacto_q;
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            out_de_q    <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            fs_q        <= 1'b0;
            line_cnt_q  <= '0;
            act_cnt_q   <= '0;
            vline_q     <= '0;
            vact_q      <= '0;
            last_htot_q <= '0;
            last_hact_q <= '0;
            htot_q      <= '0;
            hact_q      <= '0;
            vtot_q      <= '0;
            vacto_q     <= '0;
            wd_q        <= '0;
            state_q     <= SEARCH;
            match_q     <= '0;
            bad_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_de_q    <= out_de_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            fs_q        <= vs_lead;
            line_cnt_q  <= line_cnt_d;
            act_cnt_q   <= act_cnt_d;
            vline_q     <= vline_d;
            vact_q      <= vact_d;
            last_htot_q <= last_htot_d;
            last_hact_q <= last_hact_d;
            htot_q      <= htot_d;
            hact_q      <= hact_d;
            vtot_q      <= vtot_d;
            vacto_q     <= vacto_d;
            wd_q        <= wd_d;
            state_q     <= state_d;
            match_q     <= match_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_de      = out_de_q;
    assign out_sx      = sx_q;
    assign out_sy      = sy_q;
    assign frame_start = fs_q;
    assign h_total     = htot_q;
    assign h_active    = hact_q;
    assign v_total     = vtot_q;
    assign v_active    = vacto_q;
    assign locked      = locked_q;
    assign timing_err  = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder using a reduced 40x20 raster
// (32x12 active) with hsync and vsync leading edges on the same clock.
module tb_video_timing_decoder;
    localparam int CORDW = 10;
    localparam int H_TOT = 40, H_ACT = 32, HS_S = 34, HS_E = 38;
    localparam int V_TOT = 20, V_ACT = 12, VS_S = 14;

    logic             pix_clk = 1'b0;
    logic             rst_pix_n = 1'b0;
    logic             hsync = 1'b1, vsync = 1'b1, de = 1'b0;
    logic             out_de, frame_start, locked, timing_err;
    logic [CORDW-1:0] out_sx, out_sy, h_total, h_active, v_total, v_active;
    logic [7:0]       err_cnt;

    int   n_chk = 0, n_err = 0;
    int   fs_cnt = 0, te_cyc = 0, lock_fs = -1, de_cyc = 0;
    logic prev_lock = 1'b0, chk_coord = 1'b0;
    logic h1_de = 1'b0, h2_de = 1'b0;
    int   h1_x = 0, h1_y = 0, h2_x = 0, h2_y = 0;

    video_timing_decoder #(.CORDW(CORDW)) dut (
        .pix_clk(pix_clk), .rst_pix_n(rst_pix_n),
        .hsync(hsync), .vsync(vsync), .de(de),
        .out_de(out_de), .out_sx(out_sx), .out_sy(out_sy),
        .frame_start(frame_start),
        .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active),
        .locked(locked), .timing_err(timing_err), .err_cnt(err_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel: drive (active-high flags converted to active-low pins),
    // clock it, then observe outputs 1ns after the edge.
    task automatic tick(input logic h, input logic v, input logic d, input int x, input int y);
        hsync = ~h;
        vsync = ~v;
        de    = d;
        @(posedge pix_clk);
        #1;
        if (frame_start) fs_cnt++;
        if (timing_err) te_cyc++;
        if (out_de) de_cyc++;
        if (locked && !prev_lock) lock_fs = fs_cnt;
        prev_lock = locked;
        h2_de = h1_de; h2_x = h1_x; h2_y = h1_y;
        h1_de = d;     h1_x = x;    h1_y = y;
        if (chk_coord) begin
            check("out_de", 32'(out_de), 32'(h2_de));
            if (h2_de) begin
                check("out_sx", 32'(out_sx), h2_x);
                check("out_sy", 32'(out_sy), h2_y);
            end
        end
    endtask

    task automatic line(input int y, input int xend);
        for (int x = 0; x < xend; x++)
            tick(x >= HS_S && x < HS_E,
                 (y == VS_S && x >= HS_S) || (y == VS_S + 1) || (y == VS_S + 2 && x < HS_S),
                 x < H_ACT && y < V_ACT, x, y);
    endtask

    task automatic frame(input int y0, input int stretch_y, input int vlast);
        for (int y = y0; y < vlast; y++)
            line(y, (y == stretch_y) ? H_TOT + 1 : H_TOT);
    endtask

    task automatic clr_mon();
        fs_cnt = 0; te_cyc = 0; lock_fs = -1; de_cyc = 0;
    endtask

    initial begin
        // Reset held while inputs toggle randomly
        for (int i = 0; i < 40; i++) begin
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            de    = 1'($urandom_range(0, 1));
            @(posedge pix_clk);
            #1;
            check("rst_coord", 32'({out_de, out_sx, out_sy, frame_start}), 0);
            check("rst_meas", 32'({h_total, h_active, v_total}), 0);
            check("rst_stat", 32'({v_active, locked, timing_err, err_cnt}), 0);
        end
        hsync = 1'b1; vsync = 1'b1; de = 1'b0;
        @(negedge pix_clk);
        rst_pix_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);

        // Acquire lock: edge 1 measure, 2 store, 3 and 4 verify
        clr_mon();
        for (int f = 0; f < 3; f++) frame(0, -1, V_TOT);
        check("lock_early", 32'(locked), 0);
        frame(0, -1, V_TOT);
        check("lock_set", 32'(locked), 1);
        check("lock_at_fs", 32'(lock_fs), 4);
        check("fs_per_frame", 32'(fs_cnt), 4);
        check("h_total", 32'(h_total), H_TOT);
        check("h_active", 32'(h_active), H_ACT);
        check("v_total", 32'(v_total), V_TOT);
        check("v_active", 32'(v_active), V_ACT);
        check("clean_err", 32'(te_cyc), 0);
        check("clean_errcnt", 32'(err_cnt), 0);

        // Coordinates over one locked frame
        clr_mon();
        chk_coord = 1'b1;
        frame(0, -1, V_TOT);
        chk_coord = 1'b0;
        check("de_cycles", 32'(de_cyc), H_ACT * V_ACT);
        check("fs_one", 32'(fs_cnt), 1);

        // One line lengthened by a clock
        clr_mon();
        frame(0, 5, V_TOT);
        check("long_line_pulse", 32'(te_cyc), 1);
        check("long_line_errcnt", 32'(err_cnt), 1);
        check("long_line_unlock", 32'(locked), 0);
        frame(0, -1, V_TOT);
        frame(0, -1, V_TOT);
        check("relock_early", 32'(locked), 0);
        frame(0, -1, V_TOT);
        check("relock", 32'(locked), 1);
        check("relock_at_fs", 32'(lock_fs), 4);
        check("relock_pulses", 32'(te_cyc), 1);
        check("relock_h_total", 32'(h_total), H_TOT);

        // One frame with an extra blank line: caught at the vsync edge closing it
        clr_mon();
        frame(0, -1, V_TOT + 1);
        check("vlong_still_locked", 32'(locked), 1);
        check("vlong_no_err_yet", 32'(te_cyc), 0);
        frame(0, -1, V_TOT);
        check("vlong_pulse", 32'(te_cyc), 1);
        check("vlong_errcnt", 32'(err_cnt), 2);
        check("vlong_unlock", 32'(locked), 0);
        frame(0, -1, V_TOT);
        frame(0, -1, V_TOT);
        check("vlong_relock_early", 32'(locked), 0);
        frame(0, -1, V_TOT);
        check("vlong_relock", 32'(locked), 1);
        check("vlong_relock_fs", 32'(lock_fs), 5);

        // hsync missing: watchdog fires after 4095 clocks without a leading edge
        clr_mon();
        for (int i = 0; i < 4000; i++) tick(0, 0, 0, 0, 0);
        check("wd_early", 32'(te_cyc), 0);
        check("wd_early_lock", 32'(locked), 1);
        for (int i = 0; i < 200; i++) tick(0, 0, 0, 0, 0);
        check("wd_pulse", 32'(te_cyc), 1);
        check("wd_unlock", 32'(locked), 0);
        check("wd_errcnt", 32'(err_cnt), 3);
        clr_mon();
        for (int f = 0; f < 3; f++) frame(0, -1, V_TOT);
        check("wd_relock_early", 32'(locked), 0);
        frame(0, -1, V_TOT);
        check("wd_relock", 32'(locked), 1);
        check("wd_relock_fs", 32'(lock_fs), 4);

        // Asynchronous reset mid-line while locked
        for (int y = 0; y < 4; y++) line(y, H_TOT);
        line(4, 20);
        check("pre_rst_de", 32'(out_de), 1);
        check("pre_rst_lock", 32'(locked), 1);
        #2;
        rst_pix_n = 1'b0;
        #1;
        check("arst_coord", 32'({out_de, out_sx, out_sy}), 0);
        check("arst_lock", 32'(locked), 0);
        check("arst_meas", 32'({h_total, v_total}), 0);
        check("arst_errcnt", 32'(err_cnt), 0);
        @(posedge pix_clk);
        @(negedge pix_clk);
        rst_pix_n = 1'b1;
        prev_lock = 1'b0;
        clr_mon();
        frame(7, -1, V_TOT);
        frame(0, -1, V_TOT);
        frame(0, -1, V_TOT);
        check("rst_relock_early", 32'(locked), 0);
        frame(0, -1, V_TOT);
        check("rst_relock", 32'(locked), 1);
        check("rst_relock_fs", 32'(lock_fs), 4);
        check("rst_relock_errcnt", 32'(err_cnt), 0);
        check("rst_relock_h_total", 32'(h_total), H_TOT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/video_timing_decoder.md
Name: video_timing_decoder

Overview:
Receiver side of the display-signal interface: consumes a pixel-rate hsync/vsync/de stream, as driven by the display signal generator or a loopback of the DVI Pmod pins, and recovers active-area coordinates. It measures the frame geometry and reports lock and timing errors. It sits in the pix_clk domain as a self-check and capture front end for the render/display path.

Parameters:
CORDW, 10, width of coordinate and measurement outputs [bits]
HS_POL, 0, hsync active level (0 = active-low, as 640x480)
VS_POL, 0, vsync active level
LOCK_FRAMES, 2, consecutive matching frames required to assert locked
TIMEOUT_W, 12, width of no-hsync watchdog counter

Ports:
pix_clk  in  1  pixel clock
rst_pix_n  in  1  reset, asynchronous assert, active-low
hsync  in  1  incoming horizontal sync, polarity HS_POL
vsync  in  1  incoming vertical sync, polarity VS_POL
de  in  1  incoming data enable
out_de  out  1  registered de; coordinates valid when high
out_sx  out  CORDW  active column, 0..h_active-1
out_sy  out  CORDW  active row, 0..v_active-1
frame_start  out  1  1-cycle pulse on vsync leading edge
h_total  out  CORDW  measured clocks per line
h_active  out  CORDW  measured de-high clocks per line
v_total  out  CORDW  measured lines per frame
v_active  out  CORDW  measured de lines per frame
locked  out  1  geometry stable for LOCK_FRAMES frames
timing_err  out  1  1-cycle pulse on detected mismatch or timeout
err_cnt  out  8  saturating count of timing_err pulses

Behaviour:
- Reset: all outputs 0; state SEARCH; counters and stored measurements 0.
- Inputs registered once. Edges are detected on the registered copies, after polarity normalisation: "leading" = transition to the active level. Every output is registered: out_de/out_sx/out_sy follow the input de sample by exactly 2 pix_clk edges.
- out_sx: 0 on the first de-high sample of a line, +1 per de-high sample, cleared when de falls.
- out_sy: cleared on vsync leading edge, +1 on each de falling edge.
- Line counter: clocks between hsync leading edges. Frame counters: hsync leading edges and de-active lines between vsync leading edges. All counters saturate at all-ones and never wrap. A saturated value is a mismatch.
- States:
  - SEARCH: wait for vsync leading edge -> MEASURE.
  - MEASURE: accumulate one full frame. Next vsync leading edge stores h_total/h_active/v_total/v_active to the outputs, match_cnt=0 -> VERIFY.
  - VERIFY: each line's h_total/h_active is compared to the stored values. At each vsync edge, the frame v_total/v_active is compared. On a full-frame match, match_cnt++; when match_cnt reaches LOCK_FRAMES -> LOCKED, locked=1 the same edge.
  - LOCKED: same checks continue.
- Mismatch in VERIFY or LOCKED:
  - timing_err pulse and err_cnt++ (saturates at 255).
  - locked=0 on the next edge.
  - -> MEASURE from the next vsync edge; the mismatching frame is discarded.
- Watchdog: resets on each hsync leading edge. If it reaches all-ones in any state other than SEARCH: timing_err pulse, locked=0, -> SEARCH. It is inactive in SEARCH.
- Simultaneous hsync and vsync leading edges (the normal case): the line closes first, then the frame. That line counts toward the ending frame.
- de high during vsync active is legal; no special handling.
- Reset mid-frame: immediate clear. After release, the first partial frame is never measured (SEARCH waits for a full vsync edge).

Test Plan:
- Reset held, random sync toggling -> all outputs 0, locked 0, err_cnt 0.
- Clean 640x480 stream (800x525, hsync/vsync active-low) for 4 frames -> h_total=800, h_active=640, v_total=525, v_active=480; locked rises at the end of frame 3 (1 measure + 2 verify); frame_start once per frame.
- Locked stream; check coordinates -> out_sx runs 0..639 and out_sy 0..479, out_de 2 cycles after de; first active pixel gives sx=0, sy=0.
- Locked stream, one line lengthened to 801 clocks -> timing_err single pulse, err_cnt=1, locked falls; relocks after 3 clean frames.
- Locked stream, hsync held inactive for 4096 clocks -> timing_err pulse, state SEARCH, locked 0; resumed stream relocks after 3 frames.
- Asynchronous reset asserted mid-line while locked -> outputs clear immediately without a clock; after release, locked returns only after 3 full frames.
